// File: rtl/hack_mem_pkg.sv
// Shared constants and types for the Hack data-memory block.
package hack_mem_pkg;

   localparam int HACK_ADDR_W       = 15;
   localparam int HACK_DATA_W       = 16;
   localparam int HACK_RAM_WORDS    = 16384;
   localparam int HACK_SCREEN_BASE  = 16384;
   localparam int HACK_SCREEN_WORDS = 8192;
   localparam int HACK_KBD_ADDR     = 24576;

   typedef enum logic [1:0] {
      REG_RAM    = 2'd0,
      REG_SCREEN = 2'd1,
      REG_KBD    = 2'd2,
      REG_NONE   = 2'd3
   } region_t;

endpackage

// File: rtl/hack_screen_scanner.sv
// Screen scan-out: walks the screen array in order and presents one word at a
// time through a one-deep valid/ready output register. The top owns the
// screen array and serves rd_addr through a dedicated read port.
//
// state       | meaning
// ------------|--------------------------------------------------------------
// idle        | scan_valid=0, nothing presented, counter holds
// presenting  | scan_valid=1, word held until scan_ready (or reloaded)
module hack_screen_scanner
   import hack_mem_pkg::*;
#(
   parameter int SCREEN_WORDS = HACK_SCREEN_WORDS,
   parameter int SCR_AW       = $clog2(SCREEN_WORDS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   scan_en,
   input  logic                   scan_ready,
   input  logic [HACK_DATA_W-1:0] rd_data,
   output logic [SCR_AW-1:0]      rd_addr,
   output logic                   scan_valid,
   output logic [HACK_DATA_W-1:0] scan_word,
   output logic                   scan_sof
);

   localparam logic [SCR_AW-1:0] LAST_ADDR = SCR_AW'(SCREEN_WORDS - 1);

   logic load;

   // Load whenever enabled and the output register is empty or draining.
   always_comb begin
      load = scan_en && (!scan_valid || scan_ready);
   end

   // Output register and scan counter; counter only advances on a load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr    <= '0;
         scan_valid <= 1'b0;
         scan_word  <= '0;
         scan_sof   <= 1'b0;
      end else if (load) begin
         scan_word  <= rd_data;
         scan_sof   <= (rd_addr == '0);
         scan_valid <= 1'b1;
         rd_addr    <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
      end else if (!scan_en && scan_ready) begin
         scan_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, memory-mapped screen and keyboard register with a
// zero-latency CPU read port, plus screen scan-out and keyboard capture.
// Build option HACK_DATA_MEMORY_BADADDR_EN adds a sticky flag for CPU writes
// to out-of-map addresses; without it bad_addr is a constant 0.
module hack_data_memory
   import hack_mem_pkg::*;
#(
   parameter int RAM_WORDS    = HACK_RAM_WORDS,
   parameter int SCREEN_BASE  = HACK_SCREEN_BASE,
   parameter int SCREEN_WORDS = HACK_SCREEN_WORDS,
   parameter int KBD_ADDR     = HACK_KBD_ADDR
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [HACK_ADDR_W-1:0] addressM,
   input  logic [HACK_DATA_W-1:0] outM,
   input  logic                   writeM,
   output logic [HACK_DATA_W-1:0] inM,
   input  logic                   key_valid,
   input  logic [HACK_DATA_W-1:0] key_code,
   input  logic                   scan_en,
   input  logic                   scan_ready,
   output logic                   scan_valid,
   output logic [HACK_DATA_W-1:0] scan_word,
   output logic                   scan_sof,
   output logic                   bad_addr
);

   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int SCR_AW = $clog2(SCREEN_WORDS);

   localparam logic [HACK_ADDR_W-1:0] SCR_LO = HACK_ADDR_W'(SCREEN_BASE);
   localparam logic [HACK_ADDR_W-1:0] SCR_HI = HACK_ADDR_W'(SCREEN_BASE + SCREEN_WORDS);
   localparam logic [HACK_ADDR_W-1:0] KBD_A  = HACK_ADDR_W'(KBD_ADDR);

   logic [HACK_DATA_W-1:0] ram    [RAM_WORDS];
   logic [HACK_DATA_W-1:0] screen [SCREEN_WORDS];
   logic [HACK_DATA_W-1:0] kbd;

   region_t                region;
   logic [RAM_AW-1:0]      ram_idx;
   logic [SCR_AW-1:0]      scr_idx;
   logic [SCR_AW-1:0]      scan_rd_addr;
   logic [HACK_DATA_W-1:0] scan_rd_data;

   // Address decode into memory-map regions.
   always_comb begin
      region = REG_NONE;
      if (addressM < SCR_LO) begin
         region = REG_RAM;
      end else if (addressM < SCR_HI) begin
         region = REG_SCREEN;
      end else if (addressM == KBD_A) begin
         region = REG_KBD;
      end
      ram_idx = addressM[RAM_AW-1:0];
      scr_idx = SCR_AW'(addressM - SCR_LO);
   end

   // RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (writeM && region == REG_RAM) begin
         ram[ram_idx] <= outM;
      end
   end

   // Screen write port; the scanner reads the pre-edge value on a collision.
   always_ff @(posedge clk) begin
      if (writeM && region == REG_SCREEN) begin
         screen[scr_idx] <= outM;
      end
   end

   // Keyboard register; CPU writes to it are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         kbd <= '0;
      end else if (key_valid) begin
         kbd <= key_code;
      end
   end

   // Zero-latency CPU read mux.
   always_comb begin
      inM = '0;
      case (region)
         REG_RAM:    inM = ram[ram_idx];
         REG_SCREEN: inM = screen[scr_idx];
         REG_KBD:    inM = kbd;
         default:    inM = '0;
      endcase
   end

   // Second read port dedicated to scan-out.
   always_comb begin
      scan_rd_data = screen[scan_rd_addr];
   end

   hack_screen_scanner #(
      .SCREEN_WORDS (SCREEN_WORDS),
      .SCR_AW       (SCR_AW)
   ) u_scanner (
      .clk        (clk),
      .rst_n      (reset),
      .scan_en    (scan_en),
      .scan_ready (scan_ready),
      .rd_data    (scan_rd_data),
      .rd_addr    (scan_rd_addr),
      .scan_valid (scan_valid),
      .scan_word  (scan_word),
      .scan_sof   (scan_sof)
   );

`ifdef HACK_DATA_MEMORY_BADADDR_EN
   // Sticky flag for CPU writes that fall outside the memory map.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bad_addr <= 1'b0;
      end else if (writeM && region == REG_NONE) begin
         bad_addr <= 1'b1;
      end
   end
`else
   assign bad_addr = 1'b0;
`endif

endmodule

// File: tb/tb_hack_data_memory.sv
// Bench for hack_data_memory: directed memory-map cases plus randomized CPU
// traffic and randomized scan backpressure against a flat-array model.
module tb_hack_data_memory;
   import hack_mem_pkg::*;

`ifdef HACK_DATA_MEMORY_BADADDR_EN
   localparam bit BAD_EN = 1'b1;
`else
   localparam bit BAD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] addressM;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] inM;
   logic        key_valid;
   logic [15:0] key_code;
   logic        scan_en;
   logic        scan_ready;
   logic        scan_valid;
   logic [15:0] scan_word;
   logic        scan_sof;
   logic        bad_addr;

   always #5 clk = ~clk;

   hack_data_memory dut (
      .clk        (clk),
      .reset      (reset),
      .addressM   (addressM),
      .outM       (outM),
      .writeM     (writeM),
      .inM        (inM),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .scan_en    (scan_en),
      .scan_ready (scan_ready),
      .scan_valid (scan_valid),
      .scan_word  (scan_word),
      .scan_sof   (scan_sof),
      .bad_addr   (bad_addr)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] ram_m [16384];
   bit          ram_k [16384];
   logic [15:0] scr_m [8192];
   bit          scr_k [8192];
   logic [15:0] kbd_m;
   bit          bad_m;
   int          exp_idx;
   int          xfer_cnt;
   int          sof_cnt;
   bit          xfer_chk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_read(input int a);
      if (a < 16384) return ram_m[a];
      if (a < 24576) return scr_m[a - 16384];
      if (a == 24576) return kbd_m;
      return 16'h0000;
   endfunction

   function automatic bit ref_known(input int a);
      if (a < 16384) return ram_k[a];
      if (a < 24576) return scr_k[a - 16384];
      return 1'b1;
   endfunction

   task automatic chk_read(input string tag);
      int a;
      a = int'(addressM);
      if (ref_known(a)) check(tag, inM, ref_read(a));
   endtask

   // One clock: checks transfers/stalls around the edge and advances the model.
   task automatic cycle();
      bit pv, pr, pe, ps;
      logic [15:0] pw;
      int a;
      pv = scan_valid; pr = scan_ready; pe = scan_en; pw = scan_word; ps = scan_sof;
      a = int'(addressM);
      if (xfer_chk && pv && pr) begin
         check("xfer_word", pw, scr_m[exp_idx]);
         check("xfer_sof", ps, (exp_idx == 0));
         if (exp_idx == 0) sof_cnt++;
         exp_idx = (exp_idx + 1) % 8192;
         xfer_cnt++;
      end
      @(posedge clk);
      if (writeM) begin
         if (a < 16384) begin
            ram_m[a] = outM; ram_k[a] = 1'b1;
         end else if (a < 24576) begin
            scr_m[a - 16384] = outM; scr_k[a - 16384] = 1'b1;
         end else if (a != 24576) begin
            bad_m = bad_m | BAD_EN;
         end
      end
      if (key_valid) kbd_m = key_code;
      #1;
      if (pv && !pr) begin
         check("stall_valid", scan_valid, 1);
         check("stall_word", scan_word, pw);
         check("stall_sof", scan_sof, ps);
      end
      if (pe && (!pv || pr)) check("load_valid", scan_valid, 1);
      check("bad_addr", bad_addr, bad_m);
   endtask

   task automatic hold_reset();
      reset = 1'b0;
      kbd_m = 16'h0000; bad_m = 1'b0; exp_idx = 0;
      #1;
      check("rst_valid", scan_valid, 0);
      check("rst_word", scan_word, 0);
      check("rst_sof", scan_sof, 0);
      check("rst_bad", bad_addr, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_valid", scan_valid, 0);
      reset = 1'b1;
      #1;
   endtask

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bnd [6] = '{16383, 16384, 24575, 24576, 24577, 32767};
      int a, guard;
      logic [15:0] old0;

      for (int i = 0; i < 16384; i++) ram_k[i] = 1'b0;
      for (int i = 0; i < 8192; i++) scr_k[i] = 1'b0;
      kbd_m = 16'h0000; bad_m = 1'b0; exp_idx = 0; xfer_cnt = 0; sof_cnt = 0;
      xfer_chk = 1'b0;
      addressM = 15'd0; outM = 16'h0; writeM = 1'b0;
      key_valid = 1'b0; key_code = 16'h0; scan_en = 1'b0; scan_ready = 1'b0;
      reset = 1'b1;
      #3;
      hold_reset();

      addressM = 15'h6000; #1;
      check("kbd_reset", inM, 16'h0000);
      addressM = 15'h7000; #1;
      check("oom_read", inM, 16'h0000);

      // RAM write/read
      addressM = 15'd6; outM = 16'hBEEF; writeM = 1'b1; cycle();
      addressM = 15'd5; outM = 16'h1234; cycle();
      writeM = 1'b0; #1;
      check("ram_rd5", inM, 16'h1234);
      addressM = 15'd6; #1;
      check("ram_rd6", inM, 16'hBEEF);

      // Keyboard capture; same-cycle read sees the old value
      addressM = 15'h6000; key_valid = 1'b1; key_code = 16'h0041; #1;
      check("kbd_old", inM, 16'h0000);
      cycle();
      key_valid = 1'b0; #1;
      check("kbd_new", inM, 16'h0041);
      writeM = 1'b1; outM = 16'hFFFF; cycle();
      writeM = 1'b0; #1;
      check("kbd_nowrite", inM, 16'h0041);

      // Random CPU traffic over every region, scan idle
      for (int n = 0; n < 600; n++) begin
         case ($urandom % 6)
            0: a = int'($urandom % 32);
            1: a = 16384 + int'($urandom % 32);
            2: a = 24576;
            3: a = 24577 + int'($urandom % 8191);
            4: a = bnd[$urandom % 6];
            default: a = int'($urandom % 16384);
         endcase
         addressM = 15'(a);
         writeM = 1'($urandom % 2);
         outM = 16'($urandom);
         key_valid = ($urandom % 8) == 0;
         key_code = 16'($urandom);
         #1;
         chk_read("rand_rd");
         cycle();
      end
      writeM = 1'b0; key_valid = 1'b0;

      // Reset clears bad flag/kbd before scan work
      hold_reset();

      // Fill the whole screen
      writeM = 1'b1;
      for (int i = 0; i < 8192; i++) begin
         addressM = 15'(16384 + i);
         outM = (i == 0) ? 16'hAAAA : (i == 1) ? 16'h5555 : 16'($urandom);
         cycle();
      end
      writeM = 1'b0;
      addressM = 15'h4001; #1;
      check("scr_rd1", inM, 16'h5555);

      // Stream start
      xfer_chk = 1'b1; exp_idx = 0;
      scan_en = 1'b1; scan_ready = 1'b1; addressM = 15'd0;
      cycle();
      check("first_valid", scan_valid, 1);
      check("first_word", scan_word, 16'hAAAA);
      check("first_sof", scan_sof, 1);
      cycle();
      check("second_word", scan_word, 16'h5555);
      check("second_sof", scan_sof, 0);

      // Directed backpressure
      scan_ready = 1'b0;
      repeat (3) cycle();
      scan_ready = 1'b1;

      // Randomized ready/enable across a full wrap, RAM traffic alongside
      guard = 0;
      while (xfer_cnt < 8200 && guard < 40000) begin
         scan_ready = ($urandom % 4) != 0;
         scan_en = ($urandom % 10) != 0;
         addressM = 15'($urandom % 64);
         writeM = 1'($urandom % 2);
         outM = 16'($urandom);
         #1;
         chk_read("scan_rd");
         cycle();
         guard++;
      end
      writeM = 1'b0;
      check("stream_done", (xfer_cnt >= 8200), 1);
      check("sof_wrap", (sof_cnt >= 2), 1);

      // Reset mid-frame
      scan_en = 1'b1; scan_ready = 1'b1;
      repeat (5) cycle();
      #2;
      scan_en = 1'b0;
      xfer_chk = 1'b0;
      hold_reset();

      // Collision: CPU write and scan load of word 0 on the same edge
      old0 = scr_m[0];
      scan_en = 1'b1; scan_ready = 1'b0;
      addressM = 15'h4000; outM = 16'hFFFF; writeM = 1'b1;
      cycle();
      writeM = 1'b0; #1;
      check("coll_word", scan_word, old0);
      check("coll_sof", scan_sof, 1);
      check("coll_inM", inM, 16'hFFFF);

      // Next frame after reset starts at word 0
      scan_en = 1'b0;
      hold_reset();
      xfer_chk = 1'b1; exp_idx = 0; sof_cnt = 0;
      scan_en = 1'b1; scan_ready = 1'b1; addressM = 15'd5;
      repeat (20) cycle();
      check("restart_sof", (sof_cnt == 1), 1);
      scan_en = 1'b0;
      repeat (2) cycle();

      // Out-of-map write flag
      addressM = 15'h7000; outM = 16'h1234; writeM = 1'b1;
      cycle();
      writeM = 1'b0; #1;
      check("oom_rd0", inM, 16'h0000);
      check("bad_set", bad_addr, BAD_EN);
      addressM = 15'd5;
      repeat (3) cycle();
      check("bad_sticky", bad_addr, BAD_EN);
      hold_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
